inst_fetch_buffer: RTL and testbench

//  Fetch stage upstream of the single-cycle Mips datapath. Owns the fetch PC, issues word reads to a

---
 rtl/inst_fetch_buffer.sv | 151 +++++++++++++++
 tb/tb_inst_fetch_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | inst_fetch_buffer : fetch PC, imem req/ack reads, {pc,instr} FIFO         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module inst_fetch_buffer #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_out,
   output logic [31:0] pc_out
);

   localparam int               C_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int               C_CNT_W    = C_PTR_W + 1;
   localparam logic [C_CNT_W-1:0] C_FULL_CNT = C_CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [31:0]          fetch_pc_q, fetch_pc_d;
   logic                 req_q, req_d;
   logic [31:0]          addr_q, addr_d;
   logic [C_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [C_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [C_CNT_W-1:0]   count_q, count_d;
   logic [31:0]          inst_mem_q [DEPTH];
   logic [31:0]          pc_mem_q   [DEPTH];

   logic                 w_ack;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_valid;
   logic                 w_room;
   logic [31:0]          w_redir_pc;
   logic                 unused_redir_lsb;

   assign w_redir_pc       = {redirect_pc[31:2], 2'b00};
   assign unused_redir_lsb = ^redirect_pc[1:0];

   // A redirect hides the head so the downstream never consumes a flushed entry.
   assign w_valid = (count_q != '0) && !redirect_valid;
   assign w_pop   = w_valid && inst_ready;
   assign w_ack   = req_q && imem_ack;
   assign w_push  = w_ack && (state_q == S_WAIT) && !redirect_valid;
   assign w_room  = (count_d < C_FULL_CNT);

   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (redirect_valid) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         count_d  = count_q + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
         rd_ptr_d = rd_ptr_q + C_PTR_W'(w_pop);
         wr_ptr_d = wr_ptr_q + C_PTR_W'(w_push);
      end
   end

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (redirect_valid) begin
         fetch_pc_d = w_redir_pc;
      end else if (w_push) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end
   end

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      case (state_q)
         S_IDLE: begin
            if (!redirect_valid && w_room) begin
               state_d = S_WAIT;
               req_d   = 1'b1;
               addr_d  = fetch_pc_q;
            end
         end
         S_WAIT, S_DROP: begin
            // On ack the next read goes out immediately so zero-wait memory streams.
            if (w_ack) begin
               if (w_room) begin
                  state_d = S_WAIT;
                  req_d   = 1'b1;
                  addr_d  = fetch_pc_d;
               end else begin
                  state_d = S_IDLE;
                  req_d   = 1'b0;
               end
            end else if (redirect_valid) begin
               state_d = S_DROP;
            end
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         fetch_pc_q <= RESET_PC;
         req_q      <= 1'b0;
         addr_q     <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         if (w_push) begin
            inst_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]   <= addr_q;
         end
      end
   end

   assign imem_req   = req_q;
   assign imem_addr  = addr_q;
   assign inst_valid = w_valid;
   assign inst_out   = inst_mem_q[rd_ptr_q];
   assign pc_out     = pc_mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_inst_fetch_buffer : scoreboard bench for inst_fetch_buffer             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_inst_fetch_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        inst_ready = 1'b0;
   wire         imem_req;
   wire  [31:0] imem_addr;
   wire         inst_valid;
   wire  [31:0] inst_out;
   wire  [31:0] pc_out;

   int          n_pass = 0;
   int          n_total = 0;
   int          mem_lat = 0;
   bit          mem_en = 1'b0;
   int          wcnt = 0;
   logic [31:0] exp_q [$];
   logic [31:0] exp_pc;
   logic        prev_req = 1'b0;
   logic        prev_ack = 1'b0;
   logic        prev_rst = 1'b1;
   logic [31:0] prev_addr = 32'h0;

   inst_fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_out       (inst_out),
      .pc_out         (pc_out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Memory model: ack after mem_lat idle cycles of a held request.
   always @(posedge clk) begin
      #2;
      if (imem_req && mem_en) begin
         if (wcnt >= mem_lat) begin
            imem_ack   = 1'b1;
            imem_rdata = word_of(imem_addr);
            wcnt       = 0;
         end else begin
            imem_ack = 1'b0;
            wcnt++;
         end
      end else begin
         imem_ack = 1'b0;
         wcnt     = 0;
      end
   end

   // Monitor: scoreboard pops and request-hold protocol.
   always @(negedge clk) begin
      if (!rst) begin
         if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_out: got pc=%h, expected no output (t=%0t)", pc_out, $time);
            end else begin
               exp_pc = exp_q.pop_front();
               chk("pc_out", pc_out, exp_pc);
               chk("inst_out", inst_out, word_of(exp_pc));
            end
         end
         if (prev_req && !prev_ack && !prev_rst) begin
            chk("req_hold", {31'b0, imem_req}, 32'd1);
            chk("addr_hold", imem_addr, prev_addr);
         end
      end
      prev_req  <= imem_req;
      prev_ack  <= imem_ack;
      prev_rst  <= rst;
      prev_addr <= imem_addr;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step();
      rst            = 1'b1;
      mem_en         = 1'b0;
      inst_ready     = 1'b0;
      redirect_valid = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic drain(input int budget);
      int k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      chk("drain_left", exp_q.size(), 0);
   endtask

   initial begin
      // 1: streaming, one instruction per cycle
      do_reset();
      mem_lat = 0; mem_en = 1'b1; inst_ready = 1'b1;
      exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
      @(negedge clk);
      chk("t1_rst_req", {31'b0, imem_req}, 32'd0);
      chk("t1_rst_valid", {31'b0, inst_valid}, 32'd0);
      chk("t1_rst_addr", imem_addr, 32'h0);
      @(negedge clk);
      chk("t1_first_req", {31'b0, imem_req}, 32'd1);
      chk("t1_first_addr", imem_addr, 32'h0);
      for (int i = 2; i <= 6; i++) begin
         @(negedge clk);
         chk("t1_stream_valid", {31'b0, inst_valid}, 32'd1);
      end
      step();
      mem_en = 1'b0;
      @(negedge clk);
      chk("t1_last_valid", {31'b0, inst_valid}, 32'd1);
      drain(20);

      // 2: backpressure fills the FIFO, one pop frees one read
      do_reset();
      mem_lat = 0; mem_en = 1'b1; inst_ready = 1'b0;
      exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
      repeat (6) @(negedge clk);
      chk("t2_full_req", {31'b0, imem_req}, 32'd0);
      chk("t2_full_valid", {31'b0, inst_valid}, 32'd1);
      chk("t2_head_pc", pc_out, 32'h0);
      step();
      inst_ready = 1'b1;
      @(negedge clk);
      chk("t2_still_idle", {31'b0, imem_req}, 32'd0);
      step();
      inst_ready = 1'b0;
      @(negedge clk);
      chk("t2_reissue_req", {31'b0, imem_req}, 32'd1);
      chk("t2_reissue_addr", imem_addr, 32'h10);
      @(negedge clk);
      chk("t2_single_read", {31'b0, imem_req}, 32'd0);
      step();
      mem_en = 1'b0; inst_ready = 1'b1;
      drain(20);

      // 3: redirect while waiting on slow memory
      do_reset();
      mem_lat = 2; mem_en = 1'b1; inst_ready = 1'b1;
      exp_q = '{32'h100};
      step();
      step();
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      @(negedge clk);
      chk("t3_redir_addr", imem_addr, 32'h0);
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("t3_hold_req", {31'b0, imem_req}, 32'd1);
      chk("t3_hold_addr", imem_addr, 32'h0);
      @(negedge clk);
      chk("t3_new_addr", imem_addr, 32'h100);
      chk("t3_no_push", {31'b0, inst_valid}, 32'd0);
      step(); step(); step();
      mem_en = 1'b0;
      drain(20);

      // 4: redirect coincident with ack and ready, two entries buffered
      do_reset();
      mem_lat = 0; mem_en = 1'b1; inst_ready = 1'b0;
      exp_q = '{32'h200};
      step(); step(); step();
      redirect_valid = 1'b1; redirect_pc = 32'h203; inst_ready = 1'b1;
      @(negedge clk);
      chk("t4_valid_forced", {31'b0, inst_valid}, 32'd0);
      chk("t4_ack_addr", imem_addr, 32'h8);
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("t4_new_addr", imem_addr, 32'h200);
      chk("t4_flushed", {31'b0, inst_valid}, 32'd0);
      step();
      mem_en = 1'b0;
      drain(20);

      // 5: PC wraps past 2^32
      do_reset();
      mem_lat = 0; mem_en = 1'b1; inst_ready = 1'b1;
      exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
      step();
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
      @(negedge clk);
      chk("t5_first_addr", imem_addr, 32'h0);
      step();
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("t5_redir_addr", imem_addr, 32'hFFFF_FFF8);
      step(); step(); step();
      mem_en = 1'b0;
      drain(20);

      // 6: reset while a read is outstanding with three entries buffered
      do_reset();
      mem_lat = 0; mem_en = 1'b1; inst_ready = 1'b0;
      step(); step(); step(); step();
      mem_en = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("t6_pre_req", {31'b0, imem_req}, 32'd1);
      chk("t6_pre_addr", imem_addr, 32'hC);
      chk("t6_pre_valid", {31'b0, inst_valid}, 32'd1);
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_rst_req", {31'b0, imem_req}, 32'd0);
      chk("t6_rst_valid", {31'b0, inst_valid}, 32'd0);
      @(negedge clk);
      chk("t6_restart_req", {31'b0, imem_req}, 32'd1);
      chk("t6_restart_addr", imem_addr, 32'h0);
      drain(5);

      do_reset();
      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
